// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared widths, entry type and free-space threshold for the writeback collector
package wb_pkg;
  localparam int DATA_W      = 16;
  localparam int ADDR_W      = 5;
  localparam int READY_SLOTS = 2;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo_2w1r.sv
// rtl/wb_fifo_2w1r.sv - two-write one-read ordered result queue with overflow detect and address compare
module wb_fifo_2w1r #(
  parameter int  DEPTH  = 8,
  parameter int  DATA_W = wb_pkg::DATA_W,
  parameter int  ADDR_W = wb_pkg::ADDR_W,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = PTR_W + 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_push_a,
  input  logic [ADDR_W-1:0] i_addr_a,
  input  logic [DATA_W-1:0] i_data_a,
  input  logic              i_push_b,
  input  logic [ADDR_W-1:0] i_addr_b,
  input  logic [DATA_W-1:0] i_data_b,
  input  logic              i_pop,
  input  logic [ADDR_W-1:0] i_lookup_addr,
  output logic [ADDR_W-1:0] o_head_addr,
  output logic [DATA_W-1:0] o_head_data,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_overflow,
  output logic [DEPTH-1:0]  o_match
);
  logic [ADDR_W-1:0] r_addr_mem [DEPTH];
  logic [DATA_W-1:0] r_data_mem [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;
  logic              r_overflow;

  logic [CNT_W-1:0]  w_free;
  logic              w_acc_a;
  logic              w_acc_b;
  logic              w_drop;
  logic [PTR_W-1:0]  w_slot_b;

  // Free space counts this cycle's pop; A (older) claims a slot before B.
  assign w_free   = CNT_W'(DEPTH) - r_count + CNT_W'(i_pop);
  assign w_acc_a  = i_push_a && (w_free != '0);
  assign w_acc_b  = i_push_b && (w_free > CNT_W'(w_acc_a));
  assign w_drop   = (i_push_a && !w_acc_a) || (i_push_b && !w_acc_b);
  assign w_slot_b = w_acc_a ? r_tail + PTR_W'(1) : r_tail;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (i_pop) r_head <= r_head + PTR_W'(1);
      r_tail  <= r_tail + PTR_W'(w_acc_a) + PTR_W'(w_acc_b);
      r_count <= r_count + CNT_W'(w_acc_a) + CNT_W'(w_acc_b) - CNT_W'(i_pop);
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_acc_a) begin
      r_addr_mem[r_tail] <= i_addr_a;
      r_data_mem[r_tail] <= i_data_a;
    end
    if (w_acc_b) begin
      r_addr_mem[w_slot_b] <= i_addr_b;
      r_data_mem[w_slot_b] <= i_data_b;
    end
  end

  assign o_head_addr = r_addr_mem[r_head];
  assign o_head_data = r_data_mem[r_head];
  assign o_count     = r_count;
  assign o_overflow  = r_overflow;

  // An entry is live when its distance from head is below the count.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
    logic [PTR_W-1:0] w_off;
    assign w_off       = PTR_W'(gi) - r_head;
    assign o_match[gi] = ({1'b0, w_off} < r_count) && (r_addr_mem[gi] == i_lookup_addr);
  end
endmodule

// File: rtl/writeback_collector.sv
// rtl/writeback_collector.sv - serialises unit A/B results onto the single register-file write port
module writeback_collector #(
  parameter int  DEPTH  = 8,
  parameter int  DATA_W = wb_pkg::DATA_W,
  parameter int  ADDR_W = wb_pkg::ADDR_W,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              resultValidA_i,
  input  logic              isWbA_i,
  input  logic [ADDR_W-1:0] wbAddressA_i,
  input  logic [DATA_W-1:0] resultA_i,
  input  logic              resultValidB_i,
  input  logic              isWbB_i,
  input  logic [ADDR_W-1:0] wbAddressB_i,
  input  logic [DATA_W-1:0] resultB_i,
  input  logic [ADDR_W-1:0] lookupAddr_i,
  output logic              wbEnable_o,
  output logic [ADDR_W-1:0] wbAddress_o,
  output logic [DATA_W-1:0] wbData_o,
  output logic              ready_o,
  output logic              pending_o,
  output logic [CNT_W-1:0]  occupancy_o,
  output logic              overflow_o
);
  import wb_pkg::*;

  logic              w_push_a;
  logic              w_push_b;
  logic              w_pop;
  logic [CNT_W-1:0]  w_count;
  logic [ADDR_W-1:0] w_head_addr;
  logic [DATA_W-1:0] w_head_data;
  logic [DEPTH-1:0]  w_match;
  logic              w_overflow;

  logic              r_wb_en;
  logic [ADDR_W-1:0] r_wb_addr;
  logic [DATA_W-1:0] r_wb_data;

  assign w_push_a = resultValidA_i && isWbA_i;
  assign w_push_b = resultValidB_i && isWbB_i;
  assign w_pop    = (w_count != '0);

  wb_fifo_2w1r #(
    .DEPTH (DEPTH),
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_fifo (
    .i_clk        (clock_i),
    .i_rst        (reset_i),
    .i_push_a     (w_push_a),
    .i_addr_a     (wbAddressA_i),
    .i_data_a     (resultA_i),
    .i_push_b     (w_push_b),
    .i_addr_b     (wbAddressB_i),
    .i_data_b     (resultB_i),
    .i_pop        (w_pop),
    .i_lookup_addr(lookupAddr_i),
    .o_head_addr  (w_head_addr),
    .o_head_data  (w_head_data),
    .o_count      (w_count),
    .o_overflow   (w_overflow),
    .o_match      (w_match)
  );

  // Address/data hold their last written value while the strobe is low.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_wb_en   <= 1'b0;
      r_wb_addr <= '0;
      r_wb_data <= '0;
    end else begin
      r_wb_en <= w_pop;
      if (w_pop) begin
        r_wb_addr <= w_head_addr;
        r_wb_data <= w_head_data;
      end
    end
  end

  assign wbEnable_o  = r_wb_en;
  assign wbAddress_o = r_wb_addr;
  assign wbData_o    = r_wb_data;
  assign occupancy_o = w_count;
  assign overflow_o  = w_overflow;
  assign ready_o     = (CNT_W'(DEPTH) - w_count) >= CNT_W'(READY_SLOTS);
  assign pending_o   = (|w_match) || (r_wb_en && (r_wb_addr == lookupAddr_i));
endmodule
